rca_chain: RTL and testbench
============================

Name: rca_chain

Overview:
- Parameterised N-bit ripple-carry adder built from a chain of 1-bit full-adder cells; Cin enters bit 0, Cout leaves bit N-1.
- Primary sum/carry outputs are purely combinational, for use as an arithmetic primitive in the datapath (e.g. mantissa/exponent adders).
- A registered copy of the result is provided on CLOCK_50 for pipelined consumers.

Parameters:
- N, 8, operand and sum width in bits; legal range N >= 1.

Ports:
- CLOCK_50  input  1  system clock; samples the registered outputs only.
- RESET_N  input  1  asynchronous active-low reset; clears registered outputs only.
- A  input  N  operand A, unsigned.
- B  input  N  operand B, unsigned.
- Cin  input  1  carry-in to bit 0.
- S  output  N  combinational sum, (A + B + Cin) mod 2^N.
- Cout  output  1  combinational carry-out of bit N-1.
- S_Q  output  N  S registered on rising CLOCK_50.
- COUT_Q  output  1  Cout registered on rising CLOCK_50.

Behaviour:
- Structure:
  - Internal carry vector c[0..N]; c[0] = Cin.
  - For each bit i: S[i] = A[i] ^ B[i] ^ c[i]; c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i])).
  - Cout = c[N].
  - Generated with a generate loop of full-adder cells; no lookahead and no use of the "+" operator in the datapath.
- S/Cout arithmetic:
  - {Cout, S} == A + B + Cin exactly; the (N+1)-bit result never saturates.
  - Wrap-around: all-ones + 1 gives S = 0, Cout = 1.
  - Maximum (2^N - 1) + (2^N - 1) + 1 gives S = all-ones, Cout = 1.
- S/Cout timing:
  - Zero-cycle latency; independent of CLOCK_50 and RESET_N.
  - Valid after the ripple settles; the worst-case path is Cin to Cout through N cells.
- S_Q/COUT_Q:
  - Latency one cycle: on each rising CLOCK_50 edge, S_Q <= S and COUT_Q <= Cout.
  - No enable; they update every cycle.
- Reset:
  - RESET_N low asynchronously forces S_Q = 0 and COUT_Q = 0 immediately, and holds them while low.
  - Combinational S/Cout remain live during reset.
  - First capture occurs on the first rising edge after RESET_N deasserts.
  - Reset asserted mid-operation discards the captured value without affecting S/Cout.
- Inputs X or Z: no requirement. Operands are treated as unsigned; signed interpretation is left to the consumer, or provided by the optional feature.

Optional Feature:
- Macro: RCA_FLAGS_EN.
- Defined: adds the following outputs.
  - OVF (output 1): combinational signed overflow, c[N] ^ c[N-1].
  - ZERO (output 1): combinational, high when S == 0.
  - OVF_Q and ZERO_Q: registered copies on CLOCK_50, cleared to 0 by RESET_N.
- Not defined: these four ports and their logic are absent; all other behaviour is identical.

Test Plan:
- A=0x00, B=0x00, Cin=0 -> S=0x00, Cout=0; one clock later S_Q=0x00, COUT_Q=0 (ZERO=1 if RCA_FLAGS_EN).
- A=0x01, B=0x01, Cin=0 -> S=0x02, Cout=0.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1; next edge COUT_Q=1 (OVF=0, ZERO=1 if enabled).
- A=0xAA, B=0x55, Cin=0 -> S=0xFF, Cout=0; same operands with Cin=1 -> S=0x00, Cout=1 (full-length ripple).
- A=0x7F, B=0x01, Cin=0 -> S=0x80, Cout=0 (OVF=1 if enabled); A=0xFF, B=0xFF, Cin=1 -> S=0xFF, Cout=1.
- Registered path and reset:
  - With S_Q=0xFF, drive RESET_N low between clock edges -> S_Q/COUT_Q clear at once, while S still tracks inputs.
  - Release RESET_N -> S_Q equals S after the first rising edge.

Source files
------------

// File: rtl/rca_chain.sv
// rca_chain: N-bit ripple-carry adder built from a chain of 1-bit full-adder
// cells. It provides a combinational sum/carry and a registered copy clocked
// on CLOCK_50.
// Optional macro RCA_FLAGS_EN adds signed-overflow and zero flags (OVF, ZERO)
// and their registered copies (OVF_Q, ZERO_Q).
module rca_chain #(
  parameter int N = 8
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic [N-1:0] S_Q,
  output logic         COUT_Q
`ifdef RCA_FLAGS_EN
  ,
  output logic         OVF,
  output logic         ZERO,
  output logic         OVF_Q,
  output logic         ZERO_Q
`endif
);

  // Carry chain: c[0] is the carry-in, c[N] is the carry-out.
  logic [N:0] c;

  assign c[0] = Cin;

  // One full-adder cell per bit; the carry ripples from bit 0 upward.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[N];

  logic [N-1:0] s_d, s_q;
  logic         cout_d, cout_q;

`ifdef RCA_FLAGS_EN
  logic ovf_d, ovf_q;
  logic zero_d, zero_q;

  // Signed overflow is the carry into the MSB differing from the carry out of it.
  always_comb begin
    OVF  = c[N] ^ c[N-1];
    ZERO = (S == '0);
  end
`endif

  // Next-state values for the capture registers: they follow the combinational result.
  always_comb begin
    s_d    = S;
    cout_d = Cout;
`ifdef RCA_FLAGS_EN
    ovf_d  = OVF;
    zero_d = ZERO;
`endif
  end

  // Capture the result on every rising edge; asynchronous clear while reset is low.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s_q    <= '0;
      cout_q <= 1'b0;
`ifdef RCA_FLAGS_EN
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
`endif
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
`ifdef RCA_FLAGS_EN
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
`endif
    end
  end

  assign S_Q    = s_q;
  assign COUT_Q = cout_q;
`ifdef RCA_FLAGS_EN
  assign OVF_Q  = ovf_q;
  assign ZERO_Q = zero_q;
`endif

endmodule

// File: tb/tb_rca_chain.sv
// Testbench for rca_chain (N = 8): directed and random operands compared with
// an arithmetic reference model.
module tb_rca_chain;
  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] a, b;
  logic         cin;
  logic [N-1:0] s, s_q;
  logic         cout, cout_q;
`ifdef RCA_FLAGS_EN
  logic         ovf, zero, ovf_q, zero_q;
`endif

  int checks = 0;
  int errors = 0;

  // Expected values computed by the reference model.
  logic [N-1:0] exp_s;
  logic         exp_c;
  logic         exp_ovf;
  logic         exp_zero;

  rca_chain #(.N(N)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .A        (a),
    .B        (b),
    .Cin      (cin),
    .S        (s),
    .Cout     (cout),
    .S_Q      (s_q),
    .COUT_Q   (cout_q)
`ifdef RCA_FLAGS_EN
    ,
    .OVF      (ovf),
    .ZERO     (zero),
    .OVF_Q    (ovf_q),
    .ZERO_Q   (zero_q)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer addition plus a signed-range overflow test.
  task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mc);
    int unsigned total;
    int sa, sb, ssum;
    total    = int'(ma) + int'(mb) + int'(mc);
    exp_s    = N'(total % (1 << N));
    exp_c    = (total >= (1 << N));
    exp_zero = (exp_s == '0);
    sa       = ma[N-1] ? int'(ma) - (1 << N) : int'(ma);
    sb       = mb[N-1] ? int'(mb) - (1 << N) : int'(mb);
    ssum     = sa + sb + int'(mc);
    exp_ovf  = (ssum > (1 << (N-1)) - 1) || (ssum < -(1 << (N-1)));
  endtask

  task automatic check_comb(input string tag);
    check({tag, ".S"}, 32'(s), 32'(exp_s));
    check({tag, ".Cout"}, 32'(cout), 32'(exp_c));
`ifdef RCA_FLAGS_EN
    check({tag, ".OVF"}, 32'(ovf), 32'(exp_ovf));
    check({tag, ".ZERO"}, 32'(zero), 32'(exp_zero));
`endif
  endtask

  task automatic check_reg(input string tag);
    check({tag, ".S_Q"}, 32'(s_q), 32'(exp_s));
    check({tag, ".COUT_Q"}, 32'(cout_q), 32'(exp_c));
`ifdef RCA_FLAGS_EN
    check({tag, ".OVF_Q"}, 32'(ovf_q), 32'(exp_ovf));
    check({tag, ".ZERO_Q"}, 32'(zero_q), 32'(exp_zero));
`endif
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".S_Q"}, 32'(s_q), 32'h0);
    check({tag, ".COUT_Q"}, 32'(cout_q), 32'h0);
`ifdef RCA_FLAGS_EN
    check({tag, ".OVF_Q"}, 32'(ovf_q), 32'h0);
    check({tag, ".ZERO_Q"}, 32'(zero_q), 32'h0);
`endif
  endtask

  // Drive operands at a falling edge, check the combinational result, then the capture.
  task automatic step(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc;
    #1;
    model(ta, tb, tc);
    check_comb(tag);
    @(posedge clk);
    #1;
    check_reg(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    a = 8'h12; b = 8'h34; cin = 1'b0;
    #1;
    check_cleared("reset_init");
    model(8'h12, 8'h34, 1'b0);
    check_comb("comb_in_reset");
    @(posedge clk); #1;
    check_cleared("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    step("zero",      8'h00, 8'h00, 1'b0);
    step("one_one",   8'h01, 8'h01, 1'b0);
    step("wrap",      8'hFF, 8'h01, 1'b0);
    step("alt",       8'hAA, 8'h55, 1'b0);
    step("alt_ripple",8'hAA, 8'h55, 1'b1);
    step("sovf",      8'h7F, 8'h01, 1'b0);
    step("max",       8'hFF, 8'hFF, 1'b1);
    step("neg_ovf",   8'h80, 8'h80, 1'b0);
    step("pre_reset", 8'hAA, 8'h55, 1'b0);

    // Reset asserted between edges clears the capture at once; S stays live.
    #4;
    rst_n = 1'b0;
    #1;
    check_cleared("reset_async");
    a = 8'h0F; b = 8'h01; cin = 1'b1;
    #1;
    model(8'h0F, 8'h01, 1'b1);
    check_comb("comb_during_reset");
    @(posedge clk); #1;
    check_cleared("reset_edge_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_cleared("post_release_pre_edge");
    @(posedge clk); #1;
    check_reg("first_capture");

    for (int i = 0; i < 200; i++) begin
      step("rand", N'($urandom), N'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
